// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto synth units,
// preferring free, then releasing units, and stealing round-robin when all are held.
module voice_allocator #(
  parameter int NUM_UNITS     = 4,
  parameter int FREQ_WIDTH    = 16,
  parameter int NOTE_WIDTH    = 7,
  parameter int RETRIG_CYCLES = 4
) (
  input  logic                            ctl_clk,
  input  logic                            ctl_rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_note_on,
  input  logic [NOTE_WIDTH-1:0]           ev_note,
  input  logic [FREQ_WIDTH-1:0]           ev_freq,
  input  logic [NUM_UNITS-1:0]            ch_in_use,
  output logic [FREQ_WIDTH*NUM_UNITS-1:0] vco_freq_out,
  output logic [NUM_UNITS-1:0]            trigger,
  output logic [15:0]                     steal_cnt
);

  localparam int SELW = $clog2(NUM_UNITS);
  localparam int CNTW = $clog2(RETRIG_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, GAP, APPLY} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_ready;
  logic [FREQ_WIDTH-1:0] r_freq [NUM_UNITS];
  logic [NOTE_WIDTH-1:0] r_note [NUM_UNITS];
  logic [NUM_UNITS-1:0]  r_trig;
  logic [SELW-1:0]       r_stealPtr;
  logic [15:0]           r_stealCnt;
  logic [SELW-1:0]       r_sel;
  logic [CNTW-1:0]       r_gapCnt;
  logic                  r_evNoteOn;
  logic [NOTE_WIDTH-1:0] r_evNote;
  logic [FREQ_WIDTH-1:0] r_evFreq;

  logic                  w_accept;
  logic                  w_heldHit, w_freeHit, w_relHit;
  logic [SELW-1:0]       w_heldIdx, w_freeIdx, w_relIdx;

  assign w_accept  = ev_valid && r_ready;
  assign ev_ready  = r_ready;
  assign trigger   = r_trig;
  assign steal_cnt = r_stealCnt;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_pack
    assign vco_freq_out[FREQ_WIDTH*(g+1)-1 -: FREQ_WIDTH] = r_freq[g];
  end

  // Descending scan so the lowest matching unit index is the one kept.
  always_comb begin
    w_heldHit = 1'b0;
    w_freeHit = 1'b0;
    w_relHit  = 1'b0;
    w_heldIdx = '0;
    w_freeIdx = '0;
    w_relIdx  = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (r_trig[i] && (r_note[i] == r_evNote)) begin
        w_heldHit = 1'b1;
        w_heldIdx = SELW'(i);
      end
      if (!r_trig[i] && !ch_in_use[i]) begin
        w_freeHit = 1'b1;
        w_freeIdx = SELW'(i);
      end
      if (!r_trig[i] && ch_in_use[i]) begin
        w_relHit = 1'b1;
        w_relIdx = SELW'(i);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = LOOKUP;
      LOOKUP: begin
        if (!r_evNoteOn)               w_nextState = IDLE;
        else if (w_heldHit)            w_nextState = GAP;
        else if (w_freeHit || w_relHit) w_nextState = APPLY;
        else                           w_nextState = GAP;
      end
      GAP:     if (r_gapCnt == '0) w_nextState = APPLY;
      APPLY:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // ev_ready is registered so it stays low through reset and rises the cycle after.
  always_ff @(posedge ctl_clk) begin
    if (ctl_rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState == IDLE);
    end
  end

  always_ff @(posedge ctl_clk) begin
    if (ctl_rst) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_freq[i] <= '0;
        r_note[i] <= '0;
      end
      r_trig     <= '0;
      r_stealPtr <= '0;
      r_stealCnt <= '0;
      r_sel      <= '0;
      r_gapCnt   <= '0;
      r_evNoteOn <= 1'b0;
      r_evNote   <= '0;
      r_evFreq   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_evNoteOn <= ev_note_on;
            r_evNote   <= ev_note;
            r_evFreq   <= ev_freq;
          end
        end
        LOOKUP: begin
          if (!r_evNoteOn) begin
            if (w_heldHit) r_trig[w_heldIdx] <= 1'b0;
          end else if (w_heldHit) begin
            r_sel             <= w_heldIdx;
            r_trig[w_heldIdx] <= 1'b0;
            r_gapCnt          <= CNTW'(RETRIG_CYCLES - 1);
          end else if (w_freeHit) begin
            r_sel <= w_freeIdx;
          end else if (w_relHit) begin
            r_sel <= w_relIdx;
          end else begin
            r_sel              <= r_stealPtr;
            r_trig[r_stealPtr] <= 1'b0;
            r_stealCnt         <= r_stealCnt + 16'd1;
            r_gapCnt           <= CNTW'(RETRIG_CYCLES - 1);
          end
        end
        GAP: begin
          if (r_gapCnt != '0) r_gapCnt <= r_gapCnt - 1'b1;
        end
        APPLY: begin
          r_freq[r_sel] <= r_evFreq;
          r_note[r_sel] <= r_evNote;
          r_trig[r_sel] <= 1'b1;
          if (r_sel == SELW'(NUM_UNITS - 1)) r_stealPtr <= '0;
          else                               r_stealPtr <= r_sel + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation order, steal/retrigger gaps,
// note-off handling, busy-hold acceptance and reset abort mid-gap.
module tb_voice_allocator;

  logic        clk;
  logic        rst;
  logic        evValid;
  logic        evReady;
  logic        evNoteOn;
  logic [6:0]  evNote;
  logic [15:0] evFreq;
  logic [3:0]  chInUse;
  logic [63:0] vcoFreq;
  logic [3:0]  trig;
  logic [15:0] stealCnt;

  int vectors    = 0;
  int miscompares = 0;
  int acceptCnt  = 0;
  int acceptBase = 0;

  voice_allocator #(
    .NUM_UNITS(4), .FREQ_WIDTH(16), .NOTE_WIDTH(7), .RETRIG_CYCLES(4)
  ) dut (
    .ctl_clk(clk), .ctl_rst(rst), .ev_valid(evValid), .ev_ready(evReady),
    .ev_note_on(evNoteOn), .ev_note(evNote), .ev_freq(evFreq),
    .ch_in_use(chInUse), .vco_freq_out(vcoFreq), .trigger(trig),
    .steal_cnt(stealCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every handshake so a held ev_valid can be shown to produce one accept.
  always @(posedge clk) begin
    if (evValid && evReady) acceptCnt <= acceptCnt + 1;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for ev_ready, then presents one event for exactly one accept edge.
  task automatic applyStimulus(input logic on, input logic [6:0] note, input logic [15:0] freq);
    int budget = 0;
    while (!evReady && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("readyWait", 64'(evReady), 64'd1);
    if (evReady) begin
      evValid  = 1'b1;
      evNoteOn = on;
      evNote   = note;
      evFreq   = freq;
      @(posedge clk);
      @(negedge clk);
      evValid = 1'b0;
    end
  endtask

  function automatic logic [63:0] packF(input logic [15:0] f3, f2, f1, f0);
    return {f3, f2, f1, f0};
  endfunction

  initial begin
    rst = 1'b1; evValid = 1'b0; evNoteOn = 1'b0; evNote = '0; evFreq = '0; chInUse = '0;
    @(negedge clk);
    waitCycles(2);
    checkOutput("rstReady", 64'(evReady), 64'd0);
    checkOutput("rstTrig", 64'(trig), 64'd0);
    checkOutput("rstFreq", vcoFreq, 64'd0);
    checkOutput("rstSteal", 64'(stealCnt), 64'd0);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("readyAfterRst", 64'(evReady), 64'd1);

    // Four note-ons land on units 0..3, two edges after each accept.
    applyStimulus(1'b1, 7'd60, 16'd440);
    checkOutput("on0BusyReady", 64'(evReady), 64'd0);
    waitCycles(1);
    checkOutput("on0TrigE1", 64'(trig), 64'h0);
    waitCycles(1);
    checkOutput("on0TrigE2", 64'(trig), 64'h1);
    checkOutput("on0Freq", vcoFreq, packF(16'h0, 16'h0, 16'h0, 16'h01B8));
    checkOutput("on0Ready", 64'(evReady), 64'd1);
    applyStimulus(1'b1, 7'd61, 16'd494); waitCycles(2);
    applyStimulus(1'b1, 7'd62, 16'd523); waitCycles(2);
    applyStimulus(1'b1, 7'd63, 16'd587); waitCycles(2);
    checkOutput("fourTrig", 64'(trig), 64'hF);
    checkOutput("fourFreq", vcoFreq, 64'h024B_020B_01EE_01B8);
    checkOutput("fourSteal", 64'(stealCnt), 64'd0);

    // First steal hits unit 0 with a 5-cycle low gap.
    applyStimulus(1'b1, 7'd64, 16'd659);
    checkOutput("steal1E0", 64'(trig), 64'hF);
    waitCycles(1);
    checkOutput("steal1Low", 64'(trig), 64'hE);
    checkOutput("steal1Cnt", 64'(stealCnt), 64'd1);
    waitCycles(4);
    checkOutput("steal1StillLow", 64'(trig), 64'hE);
    checkOutput("steal1OldFreq", vcoFreq, 64'h024B_020B_01EE_01B8);
    waitCycles(1);
    checkOutput("steal1Rise", 64'(trig), 64'hF);
    checkOutput("steal1Freq", vcoFreq, 64'h024B_020B_01EE_0293);

    // Second steal advances round-robin to unit 1.
    applyStimulus(1'b1, 7'd66, 16'd740);
    waitCycles(1);
    checkOutput("steal2Low", 64'(trig), 64'hD);
    checkOutput("steal2Cnt", 64'(stealCnt), 64'd2);
    waitCycles(5);
    checkOutput("steal2Rise", 64'(trig), 64'hF);
    checkOutput("steal2Freq", vcoFreq, 64'h024B_020B_02E4_0293);

    // Retrigger of held note 62 reuses unit 2 without counting a steal.
    applyStimulus(1'b1, 7'd62, 16'd530);
    waitCycles(1);
    checkOutput("retrigLow", 64'(trig), 64'hB);
    waitCycles(4);
    checkOutput("retrigStillLow", 64'(trig), 64'hB);
    waitCycles(1);
    checkOutput("retrigRise", 64'(trig), 64'hF);
    checkOutput("retrigFreq", vcoFreq, 64'h024B_0212_02E4_0293);
    checkOutput("retrigSteal", 64'(stealCnt), 64'd2);

    // Note 61 is no longer held anywhere.
    applyStimulus(1'b0, 7'd61, 16'd0);
    waitCycles(1);
    checkOutput("offUnheldTrig", 64'(trig), 64'hF);
    checkOutput("offUnheldFreq", vcoFreq, 64'h024B_0212_02E4_0293);
    checkOutput("offUnheldReady", 64'(evReady), 64'd1);

    applyStimulus(1'b0, 7'd66, 16'd0);
    waitCycles(1);
    checkOutput("off66Trig", 64'(trig), 64'hD);
    checkOutput("off66Freq", vcoFreq, 64'h024B_0212_02E4_0293);
    applyStimulus(1'b0, 7'd64, 16'd0);
    waitCycles(1);
    checkOutput("off64Trig", 64'(trig), 64'hC);

    // Unit 0 releasing, unit 1 free: free wins.
    chInUse = 4'b0001;
    applyStimulus(1'b1, 7'd70, 16'd800);
    waitCycles(2);
    checkOutput("freeWinsTrig", 64'(trig), 64'hE);
    checkOutput("freeWinsFreq", vcoFreq, 64'h024B_0212_0320_0293);
    applyStimulus(1'b0, 7'd70, 16'd0);
    waitCycles(1);
    checkOutput("off70Trig", 64'(trig), 64'hC);

    // Both releasing: lowest releasing unit chosen.
    chInUse = 4'b0011;
    applyStimulus(1'b1, 7'd71, 16'd900);
    waitCycles(2);
    checkOutput("relLowTrig", 64'(trig), 64'hD);
    checkOutput("relLowFreq", vcoFreq, 64'h024B_0212_0320_0384);
    checkOutput("relLowSteal", 64'(stealCnt), 64'd2);

    // ev_valid held through busy cycles yields exactly one accept.
    chInUse = 4'b0000;
    acceptBase = acceptCnt;
    evValid = 1'b1; evNoteOn = 1'b1; evNote = 7'd72; evFreq = 16'd950;
    waitCycles(3);
    evValid = 1'b0;
    checkOutput("holdAccepts", 64'(acceptCnt - acceptBase), 64'd1);
    checkOutput("holdTrig", 64'(trig), 64'hF);
    checkOutput("holdFreq", vcoFreq, 64'h024B_0212_03B6_0384);

    // Reset asserted mid-gap of a steal on unit 2.
    applyStimulus(1'b1, 7'd73, 16'd999);
    waitCycles(1);
    checkOutput("gapStealTrig", 64'(trig), 64'hB);
    checkOutput("gapStealCnt", 64'(stealCnt), 64'd3);
    waitCycles(1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("abortTrig", 64'(trig), 64'h0);
    checkOutput("abortFreq", vcoFreq, 64'h0);
    checkOutput("abortReady", 64'(evReady), 64'd0);
    checkOutput("abortSteal", 64'(stealCnt), 64'd0);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("abortReadyBack", 64'(evReady), 64'd1);
    applyStimulus(1'b1, 7'd74, 16'd1000);
    waitCycles(2);
    checkOutput("postRstTrig", 64'(trig), 64'h1);
    checkOutput("postRstFreq", vcoFreq, 64'h0000_0000_0000_03E8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Upstream control stage for `synth`. Turns a serial stream of note-on/note-off events into the per-unit `vco_freq_in` and `trigger` buses. Reads back `ch_in_use` to choose a voice: free units first, releasing units second. When all units are held, it steals round-robin and forces a trigger low gap so the unit's EG sees a fresh rising edge.

## Interface
Parameters:
- NUM_UNITS, 4, number of synth units driven (≥2)
- FREQ_WIDTH, 16, width of one unit's frequency word
- NOTE_WIDTH, 7, note-number width
- RETRIG_CYCLES, 4, cycles of forced-low trigger gap on retrigger or steal (≥1)

Ports (one clock; reset is synchronous and active-high):
- ctl_clk  in  1  control clock, rising edge
- ctl_rst  in  1  synchronous active-high reset
- ev_valid  in  1  event present
- ev_ready  out  1  block can accept an event
- ev_note_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_WIDTH  note number
- ev_freq  in  FREQ_WIDTH  frequency word; used on note-on only
- ch_in_use  in  NUM_UNITS  per-unit "EG active", driven by `synth`
- vco_freq_out  out  FREQ_WIDTH*NUM_UNITS  unit i occupies bits [FREQ_WIDTH*(i+1)-1 : FREQ_WIDTH*i]
- trigger  out  NUM_UNITS  gate per unit, to `synth` `trigger`
- steal_cnt  out  16  number of steals since reset; wraps

## Operation
- Per-unit registers: freq[i], note[i], trigger[i]. Global registers: steal_ptr (0..NUM_UNITS-1), steal_cnt, sel, captured event.
- FSM states: IDLE, LOOKUP, GAP, APPLY. ev_ready = 1 only in IDLE and not in reset.
- IDLE: on ev_valid && ev_ready, capture ev_* and go to LOOKUP.
- LOOKUP, note-off:
  - Find the lowest i with trigger[i]=1 and note[i]=ev_note.
  - If found, clear trigger[i]. freq[i] and note[i] are kept.
  - If none is found, do nothing.
  - Next state is IDLE in both cases.
- LOOKUP, note-on, first matching rule wins:
  - (a) Same note held (trigger[i]=1 and note[i]=ev_note), lowest i: sel=i, clear trigger[i], go to GAP.
  - (b) Free unit (trigger[i]=0 and ch_in_use[i]=0), lowest i: sel=i, go to APPLY.
  - (c) Releasing unit (trigger[i]=0 and ch_in_use[i]=1), lowest i: sel=i, go to APPLY.
  - (d) Steal: sel=steal_ptr, clear trigger[sel], steal_cnt+1, go to GAP.
- ch_in_use is sampled only in LOOKUP.
- GAP: hold trigger[sel]=0 for RETRIG_CYCLES cycles (down-counter), then go to APPLY.
- APPLY:
  - freq[sel] ← ev_freq, note[sel] ← ev_note, trigger[sel] ← 1.
  - steal_ptr ← (sel+1) mod NUM_UNITS, including when sel = NUM_UNITS-1.
  - Next state is IDLE.
- Units other than sel are never modified by an event.

## Timing
- All outputs are registered.
- Reset values: trigger=0, vco_freq_out=0, note regs=0, steal_ptr=0, steal_cnt=0, state IDLE, ev_ready=0 while ctl_rst=1 and 1 on the first cycle after it.
- Event accepted at edge E0. Then:
  - note-off: trigger falls at E1; ev_ready returns high after E1.
  - note-on via (b)/(c): freq and trigger update together at E2; ev_ready returns high after E2.
  - note-on via (a)/(d): trigger falls at E1 and rises at E(2+RETRIG_CYCLES); it is low for RETRIG_CYCLES+1 cycles.
- The new freq appears on the same edge as the trigger rise. During GAP the old freq is held.
- At most one event is in flight; ev_valid held while ev_ready=0 is ignored until IDLE.
- ctl_rst asserted in any state, including mid-GAP, aborts the operation and restores all reset values on the next edge.
- A trigger that is already 0 and is cleared again stays 0; no glitch.

## Test plan
- Reset then four note-ons (notes 60..63, freq 440/494/523/587) with ch_in_use=0: triggers rise on units 0..3 in order, 2 cycles after each accept; vco_freq_out=0x024B_020B_01EE_01B8; steal_cnt=0.
- Note-off note 61: trigger[1] falls 1 cycle after accept; freq[1] stays 494.
- All four held, note-on 64/659: unit steal_ptr=0 is stolen; trigger[0] is low for 5 cycles, then rises with freq[0]=659; steal_cnt=1; a second steal goes to unit 1.
- Note-on for already-held note 62: same unit (2) gets a 5-cycle low gap then re-rises; no other trigger changes; steal_cnt unchanged.
- Units 0,1 released with ch_in_use=0b0001, units 2,3 held, note-on: unit 1 is chosen (free beats releasing); with ch_in_use=0b0011, unit 0 is chosen.
- Assert ctl_rst during GAP: next cycle all triggers=0, freq=0, ev_ready=0; after release ev_ready=1 and the next note-on goes to unit 0. Also check note-off for an unheld note (no output change) and ev_valid held through busy cycles (exactly one accept).
